// File: rtl/sad_accumulator_if.sv
// Handshake and result bundle between the SAD accumulator and its neighbours.
// The master side feeds pixels and consumes results. The slave side is the accumulator.
interface sad_accumulator_if #(
    parameter int PIX_W = 8
);
    logic               start;
    logic               pix_valid;
    logic [PIX_W-1:0]   cur_pix;
    logic [PIX_W-1:0]   ref_pix;
    logic               busy;
    logic               sad_valid;
    logic signed [31:0] sad_out;
    logic signed [31:0] x_coor;
    logic signed [31:0] y_coor;
    logic               done;

    modport master (
        output start, pix_valid, cur_pix, ref_pix,
        input  busy, sad_valid, sad_out, x_coor, y_coor, done
    );

    modport slave (
        input  start, pix_valid, cur_pix, ref_pix,
        output busy, sad_valid, sad_out, x_coor, y_coor, done
    );
endinterface

// File: rtl/sad_accumulator.sv
// Raster-scan SAD accumulator: one SAD and (x, y) per candidate displacement in the search window.
// Optional macro SAD_PIPE_REG_EN registers |cur - ref| and the pair flags once before the accumulator.
module sad_accumulator #(
    parameter int PIX_W  = 8,
    parameter int BLK_W  = 4,
    parameter int BLK_H  = 4,
    parameter int SRCH_W = 2,
    parameter int SRCH_H = 2
) (
    input logic               Clk,
    input logic               Rst,
    sad_accumulator_if.slave  bus
);

    localparam int N     = BLK_W * BLK_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int XW    = $clog2(SRCH_W + 1);
    localparam int YW    = $clog2(SRCH_H + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [XW-1:0]    X_LAST   = XW'(SRCH_W - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(SRCH_H - 1);

    localparam longint MAX_SAD = longint'(N) * ((longint'(1) << PIX_W) - 1);

    if (MAX_SAD > 64'sd2147483647) begin : g_sad_range
        $error("sad_accumulator: worst-case SAD does not fit in 31 bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [XW-1:0]    cand_x;
    logic [YW-1:0]    cand_y;
    logic [31:0]      acc;

    logic             accept;
    logic [PIX_W-1:0] absdiff;
    logic             first_pair;
    logic             last_pair;
    logic             final_pair;

    // Accumulator-side view of a pair; either the live input or a registered copy of it.
    logic             st_vld;
    logic             st_first;
    logic             st_last;
    logic             st_final;
    logic [PIX_W-1:0] st_ad;
    logic [XW-1:0]    st_x;
    logic [YW-1:0]    st_y;

    assign absdiff    = (bus.cur_pix >= bus.ref_pix) ? (bus.cur_pix - bus.ref_pix)
                                                     : (bus.ref_pix - bus.cur_pix);
    assign first_pair = (cnt == '0);
    assign last_pair  = (cnt == CNT_LAST);
    assign final_pair = last_pair && (cand_x == X_LAST) && (cand_y == Y_LAST);

`ifdef SAD_PIPE_REG_EN
    // The final pair may sit in the stage register for a cycle; hold off further input until it retires.
    assign accept = (state == ACCUM) && bus.pix_valid && !(st_vld && st_final);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_vld   <= 1'b0;
            st_first <= 1'b0;
            st_last  <= 1'b0;
            st_final <= 1'b0;
            st_ad    <= '0;
            st_x     <= '0;
            st_y     <= '0;
        end else begin
            st_vld <= accept;
            if (accept) begin
                st_first <= first_pair;
                st_last  <= last_pair;
                st_final <= final_pair;
                st_ad    <= absdiff;
                st_x     <= cand_x;
                st_y     <= cand_y;
            end
        end
    end
`else
    assign accept   = (state == ACCUM) && bus.pix_valid;
    assign st_vld   = accept;
    assign st_first = first_pair;
    assign st_last  = last_pair;
    assign st_final = final_pair;
    assign st_ad    = absdiff;
    assign st_x     = cand_x;
    assign st_y     = cand_y;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = ACCUM;
            ACCUM:   if (st_vld && st_last && st_final) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt    <= '0;
            cand_x <= '0;
            cand_y <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cnt    <= '0;
            cand_x <= '0;
            cand_y <= '0;
        end else if (accept) begin
            if (last_pair) begin
                cnt <= '0;
                if (cand_x == X_LAST) begin
                    cand_x <= '0;
                    cand_y <= (cand_y == Y_LAST) ? '0 : cand_y + 1'b1;
                end else begin
                    cand_x <= cand_x + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The first pair of a candidate reloads acc, so no clear cycle sits between candidates.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc           <= '0;
            bus.sad_out   <= '0;
            bus.x_coor    <= '0;
            bus.y_coor    <= '0;
            bus.sad_valid <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.sad_valid <= 1'b0;
            bus.done      <= 1'b0;
            if (st_vld) begin
                acc <= st_first ? 32'(st_ad) : acc + 32'(st_ad);
                if (st_last) begin
                    bus.sad_out   <= (st_first ? 32'd0 : acc) + 32'(st_ad);
                    bus.x_coor    <= 32'(st_x);
                    bus.y_coor    <= 32'(st_y);
                    bus.sad_valid <= 1'b1;
                    bus.done      <= st_final;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: doc/sad_accumulator.md
Name: sad_accumulator

Overview:
- Upstream feeder for the VBSME best-SAD compare stage.
- Walks a search window in raster order, accumulating |cur - ref| over one BLK_W x BLK_H block for each candidate displacement.
- Emits one SAD plus its (x, y) candidate coordinate per candidate, with a one-cycle valid strobe, for the minimum-tracking stage to consume.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- BLK_W, 4, block width in pixels.
- BLK_H, 4, block height in pixels.
- SRCH_W, 2, candidate positions per row.
- SRCH_H, 2, candidate rows.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new search-window scan; accepted only in IDLE.
- pix_valid  input  1  cur_pix/ref_pix pair valid this cycle; ignored outside ACCUM.
- cur_pix  input  PIX_W  current-frame block pixel (unsigned).
- ref_pix  input  PIX_W  reference-frame pixel for the current candidate (unsigned).
- busy  output  1  high in ACCUM and DONE.
- sad_valid  output  1  one-cycle strobe: sad_out, x_coor and y_coor hold a finished candidate.
- sad_out  output  32  signed SAD, always non-negative.
- x_coor  output  32  signed candidate column, 0..SRCH_W-1.
- y_coor  output  32  signed candidate row, 0..SRCH_H-1.
- done  output  1  one-cycle strobe after the last candidate is emitted.

Behaviour:
- Interface: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values: busy=0, sad_valid=0, done=0, sad_out=0, x_coor=0, y_coor=0. Internal: acc=0, pixel count=0, candidate x=0, candidate y=0, state=IDLE.
- Pixel order: BLK_W*BLK_H = N pixel pairs per candidate, raster order within the block. Candidates are taken x-fastest, then y.
- Pairs are counted only on cycles with pix_valid=1. Gaps of any length are allowed and freeze all counters and the accumulator.
- Absolute difference: absdiff = cur_pix >= ref_pix ? cur_pix - ref_pix : ref_pix - cur_pix. Width PIX_W, zero-extended to 32 bits.
- Accumulation: on the first pair of a candidate (count==0), acc <= absdiff. The previous acc is discarded; no separate clear cycle. Otherwise acc <= acc + absdiff.
- Emission: on the N-th valid pair, on the next rising edge:
  - sad_out <= acc + absdiff;
  - x_coor and y_coor <= the current candidate indices;
  - sad_valid <= 1 for exactly one cycle.
- After emission, the candidate index advances: x wraps to 0 at SRCH_W-1 and y increments.
- Output hold: sad_out, x_coor and y_coor hold their values until the next emission. The downstream stage samples them on the negative edge while sad_valid=1.
- Latency: sad_valid rises 1 cycle after the final pair of a candidate.
- State IDLE: busy=0. start=1 -> ACCUM, with counts cleared to 0.
- State ACCUM: busy=1. The final pair of the final candidate (x=SRCH_W-1, y=SRCH_H-1) -> DONE.
- State DONE: lasts one cycle. done=1 and sad_valid=1 for the final candidate in that same cycle, then -> IDLE.
- start while busy: ignored; it does not restart the scan or clear counters.
- start and pix_valid in the same IDLE cycle: that pix_valid is ignored. The first counted pair arrives no earlier than the cycle after start.
- Rst mid-scan: returns immediately to the reset values. No partial sad_valid or done is emitted.
- Overflow: cannot occur within parameter limits. The maximum SAD is (2^PIX_W - 1)*N, which must fit in 31 bits; this is an elaboration-time check.

Optional Feature:
- Macro: SAD_PIPE_REG_EN.
- When defined: absdiff and its "last pair" flag are registered once before the accumulator. sad_valid then rises 2 cycles after the final pair, and done moves with it. Count and state sequencing are otherwise identical.
- When undefined: the single-cycle path described above, with sad_valid 1 cycle after the final pair.

Test Plan:
- Reset, pulse start, 64 back-to-back pairs with cur=10, ref=7 -> four sad_valid pulses, each sad_out=48, coordinates (0,0), (1,0), (0,1), (1,1); done coincident with the 4th pulse; busy=0 the cycle after.
- Pairs cur=0, ref=255 for candidate 0 and cur=255, ref=0 for candidate 1 -> sad_out=4080 both times, confirming the symmetric absolute difference with no sign error.
- Candidate 0 pixels cur=i, ref=0 for i=0..15 -> sad_out=120. Candidate 1 all-equal pixels -> sad_out=0, confirming acc reloads with no carry-over.
- pix_valid toggled 1,0,0,1,... with random gaps across one full scan -> same SADs as the gapless run, one sad_valid per 16 accepted pairs.
- start reasserted mid-ACCUM -> no effect. Rst asserted after 9 pairs -> all outputs 0, no sad_valid. A new start gives a correct full scan from (0,0).
- Same as the first scenario with SAD_PIPE_REG_EN defined -> identical values, each sad_valid and done one cycle later.
